// File: rtl/sync_dd.sv
// Multi-flop synchronizer: each input bit crosses into the clk domain through
// its own chain of STAGES flops, with no logic between stages.

module sync_dd_lane #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset_,
    input  logic d_i,
    output logic q_o
);

    // Kept as discrete flops next to each other so tools neither retime them
    // nor fold the chain into an SRL, which would defeat metastability settling.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) stage_q <= {STAGES{RST_BIT}};
        else         stage_q <= stage_d;
    end

    assign q_o = stage_q[STAGES-1];

endmodule

module sync_dd #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          STAGES    = 2,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_out
);

    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $error("sync_dd: STAGES must be in 2..8");
    end

    // Bits are synchronized independently; no cross-bit coherency is implied.
    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        sync_dd_lane #(
            .STAGES  (STAGES),
            .RST_BIT (RESET_VAL[l])
        ) u_lane (
            .clk    (clk),
            .reset_ (reset_),
            .d_i    (sync_in[l]),
            .q_o    (sync_out[l])
        );
    end

endmodule

// File: tb/tb_sync_dd.sv
// Bench for sync_dd: two configurations checked every cycle against a
// sample-queue model, plus directed literal checks and a UART 8N1 frame.
`timescale 1ns/1ps

module tb_sync_dd;

    localparam int    SB    = 3;
    localparam logic [3:0] RVB = 4'hA;
    localparam int    BIT_CYC = 868;   // 100 MHz / 115200 baud

    logic       clk = 1'b0;
    logic       reset_ = 1'b1;
    logic       in_a = 1'b0;
    logic       out_a;
    logic [3:0] in_b = 4'h0;
    logic [3:0] out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_dd u_a (
        .clk      (clk),
        .reset_   (reset_),
        .sync_in  (in_a),
        .sync_out (out_a)
    );

    sync_dd #(.WIDTH(4), .STAGES(SB), .RESET_VAL(RVB)) u_b (
        .clk      (clk),
        .reset_   (reset_),
        .sync_in  (in_b),
        .sync_out (out_b)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: output equals the sample taken STAGES edges ago; before that many
    // samples exist since reset release, it is the reset value.
    logic       qa[$];
    logic [3:0] qb[$];

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            qa.delete();
            qb.delete();
        end else begin
            qa.push_back(in_a);
            qb.push_back(in_b);
            if (qa.size() > 2)  void'(qa.pop_front());
            if (qb.size() > SB) void'(qb.pop_front());
        end
    end

    always @(negedge clk) begin
        chk("cmp_a", {3'b0, out_a}, {3'b0, (qa.size() == 2) ? qa[0] : 1'b0});
        chk("cmp_b", out_b, (qb.size() == SB) ? qb[0] : RVB);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic uart_drive(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(posedge clk);
        #3;
        for (int i = 0; i < 10; i++) begin
            in_a = frame[i];
            #(BIT_CYC * 10);
        end
    endtask

    task automatic uart_decode(output logic [7:0] b, output logic ok);
        int n;
        b  = 8'h00;
        ok = 1'b0;
        n  = 0;
        while (out_a !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) return;
        repeat (BIT_CYC / 2) step();
        if (out_a !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) step();
            b[i] = out_a;
        end
        repeat (BIT_CYC) step();
        ok = (out_a === 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        logic       ok;

        #2 reset_ = 1'b0;
        repeat (3) step();
        chk("rst_a", {3'b0, out_a}, 4'h0);
        chk("rst_b", out_b, 4'hA);

        // Latency: input rises before edge 0
        #2 reset_ = 1'b1;
        in_a = 1'b1;
        in_b = 4'h5;
        step();
        chk("lat_a_e0", {3'b0, out_a}, 4'h0);
        chk("lat_b_e0", out_b, 4'hA);
        step();
        chk("lat_a_e1", {3'b0, out_a}, 4'h1);
        chk("lat_b_e1", out_b, 4'hA);
        step();
        chk("lat_b_e2", out_b, 4'h5);

        // Falling edge after a long high
        repeat (10) step();
        in_a = 1'b0;
        step();
        chk("fall_e0", {3'b0, out_a}, 4'h1);
        step();
        chk("fall_e1", {3'b0, out_a}, 4'h0);
        repeat (5) begin
            step();
            chk("fall_hold", {3'b0, out_a}, 4'h0);
        end

        // Toggling stream, then asynchronous reset mid-cycle
        for (int i = 0; i < 12; i++) begin
            in_a = ~in_a;
            in_b = 4'(i * 7 + 3);
            step();
        end
        in_a = 1'b1;
        #2 reset_ = 1'b0;
        #1;
        chk("async_rst_a", {3'b0, out_a}, 4'h0);
        chk("async_rst_b", out_b, 4'hA);
        step();
        #2 reset_ = 1'b1;
        in_a = 1'b1;
        in_b = 4'h3;
        step();
        chk("rel_a_e0", {3'b0, out_a}, 4'h0);
        step();
        chk("rel_a_e1", {3'b0, out_a}, 4'h1);
        chk("rel_b_e1", out_b, 4'hA);
        step();
        chk("rel_b_e2", out_b, 4'h3);

        // Directed multi-bit patterns on the wide instance
        in_b = 4'hF; step();
        in_b = 4'h0; step();
        in_b = 4'h9; step();
        chk("pat_b_F", out_b, 4'hF);
        step();
        chk("pat_b_0", out_b, 4'h0);
        step();
        chk("pat_b_9", out_b, 4'h9);

        // UART 8N1 frame 'A' through the default synchronizer
        in_a = 1'b1;
        repeat (20) step();
        fork
            uart_drive(8'h41);
            uart_decode(rx, ok);
        join
        chk("uart_frame_ok", {3'b0, ok}, 4'h1);
        checks++;
        if (rx !== 8'h41) begin
            errors++;
            $display("FAIL uart_byte: got %h expected 41", rx);
        end

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
